// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider family.
//
// Contents:
//   clkdiv_mode_e - output mode selector.
//                   MODE_TOGGLE produces a 50%-duty divided clock.
//                   MODE_PULSE produces a one-cycle strobe.
//   DIV_250K, DIV_25K, DIV_2K5, DIV_250 - terminal counts for the standard
//                   rates used by the old fixed divider. Any of them can be
//                   used as DEFAULT_DIV.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

  localparam int DIV_250K = 250000;
  localparam int DIV_25K  = 25000;
  localparam int DIV_2K5  = 2500;
  localparam int DIV_250  = 250;

endpackage

// File: rtl/clkdiv_counter.sv
// Free-running terminal counter for the programmable clock divider.
//
// The count runs from 0 up to terminal_val, then wraps to 0.
// Wrapping only happens on an exact CNT_W-bit match, so there is no
// other wrap point.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset, clears the count
//   clear        - synchronous phase restart, clears the count
//   en           - count enable; when low the count holds
//   terminal_val - terminal count T currently in use
//   terminal     - high while count == terminal_val
module clkdiv_counter #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal_val,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  assign terminal = (count == terminal_val);

  // Count up while enabled and wrap to zero after the terminal value.
  // The wrap at terminal also serves as the count reset when a new setting
  // commits at a period boundary, because commits only happen at terminal.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider.
//
// Modes:
//   Toggle mode produces div_clk with period 2*(T+1) and 50% duty.
//   Pulse mode produces div_tick, a one-cycle strobe with period T+1.
//
// New divisor/mode settings are staged in a pending register. They only
// take effect at a full output-period boundary, or on restart, so the
// output never glitches.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   en         - count enable; low freezes counter and div_clk,
//                and forces div_tick low
//   restart    - synchronous phase restart; also commits any pending setting
//   div_load   - strobe capturing div_val/mode_val as the pending setting
//   div_val    - requested terminal count T
//   mode_val   - requested mode (0 toggle, 1 pulse)
//   div_clk    - divided clock (toggle mode only, else 0)
//   div_tick   - one-cycle strobe (pulse mode only, else 0)
//   pending    - a staged setting is waiting for a boundary
//   active_div - terminal count currently in use
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W        = 19,
  parameter int DEFAULT_DIV  = DIV_250K,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic             mode_val,
  output logic             div_clk,
  output logic             div_tick,
  output logic             pending,
  output logic [CNT_W-1:0] active_div
);

  clkdiv_mode_e     mode;
  clkdiv_mode_e     pend_mode;
  logic [CNT_W-1:0] pend_div;
  logic             terminal;
  logic             at_boundary;
  logic             commit_now;

  clkdiv_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .en          (en),
    .terminal_val(active_div),
    .terminal    (terminal)
  );

  // A period ends at the falling edge of div_clk in toggle mode.
  // In pulse mode, every terminal event ends a period.
  // A pending setting commits there, or immediately on restart.
  always_comb begin
    at_boundary = terminal && ((mode == MODE_PULSE) || div_clk);
    commit_now  = pending && (restart || (en && at_boundary));
  end

  // Staging register, active setting and registered outputs.
  //
  // The commit happens first, then the load. So a load arriving in the
  // same cycle as a commit becomes the next pending setting instead of
  // being lost.
  //
  // Mode switches need no special handling for div_clk. A toggle->pulse
  // commit happens exactly as div_clk falls. In pulse mode, div_clk never
  // leaves 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_clk    <= 1'b0;
      div_tick   <= 1'b0;
      pending    <= 1'b0;
      active_div <= CNT_W'(DEFAULT_DIV);
      mode       <= clkdiv_mode_e'(DEFAULT_MODE);
      pend_div   <= CNT_W'(DEFAULT_DIV);
      pend_mode  <= clkdiv_mode_e'(DEFAULT_MODE);
    end else begin
      if (commit_now) begin
        active_div <= pend_div;
        mode       <= pend_mode;
      end

      if (div_load) begin
        pend_div  <= div_val;
        pend_mode <= clkdiv_mode_e'(mode_val);
        pending   <= 1'b1;
      end else if (commit_now) begin
        pending <= 1'b0;
      end

      if (restart) begin
        div_clk  <= 1'b0;
        div_tick <= 1'b0;
      end else if (en) begin
        div_tick <= terminal && (mode == MODE_PULSE);
        if (terminal && (mode == MODE_TOGGLE)) begin
          div_clk <= ~div_clk;
        end
      end else begin
        div_tick <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed 4-setting clock divider.
- Produces a 50%-duty divided clock (toggle mode) or a one-cycle strobe (pulse mode) from the system clock.
- Divisor and mode changes are staged and committed only at a full output-period boundary, so the output never glitches.
- Feeds display scan, debounce and blink logic that today use hard-coded divider settings.

Parameters:
- CNT_W, 19, width of counter and divisor values.
- DEFAULT_DIV, 250000, terminal count loaded at reset; must fit in CNT_W.
- DEFAULT_MODE, 0, mode at reset: 0 = toggle, 1 = pulse.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes counter and outputs.
- restart  in  1  synchronous phase restart (single-cycle pulse).
- div_load  in  1  single-cycle strobe; captures div_val and mode_val into the pending register.
- div_val  in  CNT_W  requested terminal count T.
- mode_val  in  1  requested mode.
- div_clk  out  1  divided clock, toggle mode only; held 0 in pulse mode.
- div_tick  out  1  one-cycle strobe, pulse mode only; held 0 in toggle mode.
- pending  out  1  a loaded setting is waiting for a boundary.
- active_div  out  CNT_W  terminal count currently in use.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: count = 0, div_clk = 0, div_tick = 0, pending = 0, active_div = DEFAULT_DIV, active mode = DEFAULT_MODE.
- Priority: reset > restart > en.
- Counting (en = 1): count increments by 1 per clk.
- Terminal event: when count == active_div, count is set to 0 next cycle. No other wrap exists.
- Toggle mode: div_clk inverts on each terminal event, giving period 2*(T+1) clk cycles at 50% duty. T = 0 gives clk/2.
- Pulse mode: div_tick is registered high for exactly the one cycle after each terminal event, giving period T+1. T = 0 gives div_tick constantly high.
- Period-end boundary:
  - Toggle mode: a terminal event while div_clk == 1 (the falling edge).
  - Pulse mode: every terminal event.
- Commit at boundary: if pending = 1, active_div and mode take the pending values, pending clears, and count = 0.
- Mode switch on commit:
  - toggle→pulse: div_clk stays 0.
  - pulse→toggle: div_clk starts 0.
- Load with no boundary in the same cycle: the pending register is overwritten (last load wins) and pending = 1.
- Load in the same cycle as a boundary: any previously pending value commits; the new value becomes pending for the next boundary. If nothing was pending, the new value waits for the next boundary.
- en = 0: count, div_clk and the active setting hold; div_tick = 0; loads are still captured.
- restart:
  - count = 0, div_clk = 0, div_tick = 0.
  - If pending = 1, it commits immediately and clears.
  - A div_load in the same cycle is captured as pending and is not committed.
- Counter width: comparison is exact equality on CNT_W bits.
- Reset mid-period: outputs are forced to their reset values next cycle and any pending setting is discarded.

Decomposition:
- Shared package clkdiv_pkg: mode constants MODE_TOGGLE = 1'b0 and MODE_PULSE = 1'b1, plus DEFAULT_DIV values for the standard 250000, 25000, 2500 and 250 rates.
- One natural sub-module, clkdiv_counter: the CNT_W counter with terminal-compare output.
- Staging register and output logic stay in the top level.

Test Plan:
- Reset held 3 cycles, then released with DEFAULT_DIV = 3 and toggle mode → div_clk is 0 for 4 cycles, then 1 for 4, period 8; active_div = 3, pending = 0.
- Load T = 1 mid-high-phase while running with T = 3 → pending = 1 until the falling edge; the old 4-cycle high phase completes; afterwards the period is 4 cycles; pending = 0.
- Pulse mode with T = 4, then en low for 7 cycles mid-count → div_tick spacing of 5 cycles excluding the frozen cycles; div_tick = 0 throughout the freeze.
- Two loads back-to-back (T = 9, then T = 2) before a boundary → only T = 2 commits; active_div = 2.
- Load coinciding with a boundary while T = 5 is already pending → T = 5 commits now; the new value commits at the following boundary.
- restart with pending T = 6 in toggle mode → next cycle count = 0, div_clk = 0, active_div = 6; first high edge comes 7 cycles later.
